// File: rtl/image_bram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : image_bram_writer
//  Description : Snapshots a parallel pixel array and writes it, packed
//                several pixels per word, into a shared single-port BRAM in
//                raster order. Each write waits for the BRAM port grant.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                 system clock, rising edge
//    rst_n               asynchronous active-low reset
//    i_store_start       start pulse, only honoured while idle
//    i_image_buffer_in   image; index NUM-1 is raster pixel 0 (top-left)
//    i_bram_gnt          BRAM port grant; a write only happens while high
//    o_bram_addr         BRAM word address
//    o_bram_ena          BRAM enable
//    o_bram_wea          BRAM write enable (same as o_bram_ena)
//    o_bram_din          packed write data, raster pixel 8k in the top byte
//    o_storing_busy      high from accepted start until done
//    o_store_done        single-cycle completion pulse
//    o_checksum          (IMG_WR_CHECKSUM_EN only) sum of written pixels
//                        mod 2^16
//  Build option
//    IMG_WR_CHECKSUM_EN  adds the o_checksum output and its accumulator
// ============================================================================
module image_bram_writer #(
    parameter int P_NUM_INPUT_PIXELS      = 784,
    parameter int P_PIXEL_INTENSITY_BITS  = 8,
    parameter int P_IMAGE_BRAM_DATA_WIDTH = 64,
    parameter int P_IMAGE_BRAM_DEPTH      = 98
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   i_store_start,
    input  logic [P_NUM_INPUT_PIXELS-1:0][P_PIXEL_INTENSITY_BITS-1:0] i_image_buffer_in,
    input  logic                                                   i_bram_gnt,
    output logic [$clog2(P_IMAGE_BRAM_DEPTH)-1:0]                  o_bram_addr,
    output logic                                                   o_bram_ena,
    output logic                                                   o_bram_wea,
    output logic [P_IMAGE_BRAM_DATA_WIDTH-1:0]                     o_bram_din,
    output logic                                                   o_storing_busy,
    output logic                                                   o_store_done
`ifdef IMG_WR_CHECKSUM_EN
    ,
    output logic [15:0]                                            o_checksum
`endif
);

    localparam int C_PB     = P_PIXEL_INTENSITY_BITS;
    localparam int C_DW     = P_IMAGE_BRAM_DATA_WIDTH;
    localparam int C_PPW    = C_DW / C_PB;
    localparam int C_ADDR_W = $clog2(P_IMAGE_BRAM_DEPTH);
    localparam int C_CNT_W  = $clog2(P_IMAGE_BRAM_DEPTH + 1);
    // Raster index width must hold DEPTH*PPW itself so the "past the end of
    // the image" comparison cannot wrap.
    localparam int C_RIDX_W = $clog2(P_IMAGE_BRAM_DEPTH * C_PPW + 1);
    localparam int C_SIDX_W = $clog2(P_NUM_INPUT_PIXELS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                                               r_state;
    state_t                                               w_state_nxt;
    logic [P_NUM_INPUT_PIXELS-1:0][C_PB-1:0]              r_snap;
    logic [C_CNT_W-1:0]                                   r_count;
    logic [C_CNT_W-1:0]                                   w_count_nxt;
    logic [C_ADDR_W-1:0]                                  r_addr;
    logic [C_ADDR_W-1:0]                                  w_addr_nxt;
    logic                                                 r_ena;
    logic                                                 w_ena_nxt;
    logic [C_DW-1:0]                                      r_din;
    logic [C_DW-1:0]                                      w_din_nxt;
    logic                                                 r_busy;
    logic                                                 w_busy_nxt;
    logic                                                 r_done;
    logic                                                 w_done_nxt;
    logic                                                 w_snap_load;
    logic [C_RIDX_W-1:0]                                  w_base;
    logic [C_DW-1:0]                                      w_pack;

    // ------------------------------------------------------------------
    // Word packing: lane j of word k carries raster pixel k*PPW+j, lane 0
    // in the most significant byte. Raster pixel r lives at snapshot index
    // NUM-1-r; raster indices beyond the image pad with zero.
    // ------------------------------------------------------------------
    assign w_base = C_RIDX_W'(r_count) * C_RIDX_W'(C_PPW);

    generate
        for (genvar j = 0; j < C_PPW; j++) begin : g_lane
            logic [C_RIDX_W-1:0] w_ridx;
            logic [C_SIDX_W-1:0] w_sidx;
            logic                w_in_image;

            assign w_ridx     = w_base + C_RIDX_W'(j);
            assign w_in_image = (w_ridx < C_RIDX_W'(P_NUM_INPUT_PIXELS));
            assign w_sidx     = C_SIDX_W'(C_RIDX_W'(P_NUM_INPUT_PIXELS - 1) - w_ridx);
            assign w_pack[C_DW-1-j*C_PB -: C_PB] = w_in_image ? r_snap[w_sidx] : '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_addr_nxt  = r_addr;
        w_din_nxt   = r_din;
        w_busy_nxt  = r_busy;
        w_ena_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_snap_load = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_store_start) begin
                    w_snap_load = 1'b1;
                    w_count_nxt = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                // The terminal check wins over the grant so the address
                // can never run past DEPTH-1.
                if (r_count == C_CNT_W'(P_IMAGE_BRAM_DEPTH)) begin
                    w_state_nxt = S_DONE;
                end else if (i_bram_gnt) begin
                    w_ena_nxt   = 1'b1;
                    w_addr_nxt  = C_ADDR_W'(r_count);
                    w_din_nxt   = w_pack;
                    w_count_nxt = r_count + C_CNT_W'(1);
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and word counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_addr  <= '0;
            r_ena   <= 1'b0;
            r_din   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_addr  <= w_addr_nxt;
            r_ena   <= w_ena_nxt;
            r_din   <= w_din_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Snapshot is taken once at start so later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap <= '0;
        end else if (w_snap_load) begin
            r_snap <= i_image_buffer_in;
        end
    end

    assign o_bram_addr    = r_addr;
    assign o_bram_ena     = r_ena;
    assign o_bram_wea     = r_ena;
    assign o_bram_din     = r_din;
    assign o_storing_busy = r_busy;
    assign o_store_done   = r_done;

`ifdef IMG_WR_CHECKSUM_EN
    // ------------------------------------------------------------------
    // Running pixel sum, accumulated from the same word that is written.
    // ------------------------------------------------------------------
    logic [C_PPW:0][15:0] w_psum;
    logic [15:0]          r_checksum;

    assign w_psum[0] = 16'd0;

    generate
        for (genvar j = 0; j < C_PPW; j++) begin : g_csum
            assign w_psum[j+1] = w_psum[j] + 16'(w_pack[C_DW-1-j*C_PB -: C_PB]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= 16'd0;
        end else if (w_snap_load) begin
            r_checksum <= 16'd0;
        end else if (w_ena_nxt) begin
            r_checksum <= r_checksum + w_psum[C_PPW];
        end
    end

    assign o_checksum = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_image_bram_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_image_bram_writer
//  Description : Self-checking bench for image_bram_writer. A raster-order
//                reference model predicts every output on every cycle; a
//                second instance with a 780-pixel image covers zero padding.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_image_bram_writer;

    localparam int NUM   = 784;
    localparam int NUM2  = 780;
    localparam int PB    = 8;
    localparam int DW    = 64;
    localparam int DEPTH = 98;
    localparam int AW    = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic gnt   = 1'b0;
    logic [NUM-1:0][PB-1:0]  img;
    logic [NUM2-1:0][PB-1:0] img2;

    logic [AW-1:0] o_addr,  o2_addr;
    logic          o_ena,   o2_ena;
    logic          o_wea,   o2_wea;
    logic [DW-1:0] o_din,   o2_din;
    logic          o_busy,  o2_busy;
    logic          o_done,  o2_done;
`ifdef IMG_WR_CHECKSUM_EN
    logic [15:0]   o_csum,  o2_csum;
`endif

    always #5 clk = ~clk;

    image_bram_writer #(
        .P_NUM_INPUT_PIXELS(NUM), .P_PIXEL_INTENSITY_BITS(PB),
        .P_IMAGE_BRAM_DATA_WIDTH(DW), .P_IMAGE_BRAM_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_store_start(start),
        .i_image_buffer_in(img), .i_bram_gnt(gnt),
        .o_bram_addr(o_addr), .o_bram_ena(o_ena), .o_bram_wea(o_wea),
        .o_bram_din(o_din), .o_storing_busy(o_busy), .o_store_done(o_done)
`ifdef IMG_WR_CHECKSUM_EN
        , .o_checksum(o_csum)
`endif
    );

    image_bram_writer #(
        .P_NUM_INPUT_PIXELS(NUM2), .P_PIXEL_INTENSITY_BITS(PB),
        .P_IMAGE_BRAM_DATA_WIDTH(DW), .P_IMAGE_BRAM_DEPTH(DEPTH)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .i_store_start(start),
        .i_image_buffer_in(img2), .i_bram_gnt(gnt),
        .o_bram_addr(o2_addr), .o_bram_ena(o2_ena), .o_bram_wea(o2_wea),
        .o_bram_din(o2_din), .o_storing_busy(o2_busy), .o_store_done(o2_done)
`ifdef IMG_WR_CHECKSUM_EN
        , .o_checksum(o2_csum)
`endif
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (raster order) ----------------
    byte unsigned cur_raster [NUM];
    byte unsigned m_snap     [NUM];
    int           m_phase = 0;   // 0 idle, 1 writing, 2 finishing
    int           m_k     = 0;
    logic          e_ena  = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_din  = '0;
    logic [DW-1:0] e_din2 = '0;
    logic          e_busy = 1'b0;
    logic          e_done = 1'b0;
    logic [15:0]   e_csum = '0;

    // Word k = raster pixels 8k..8k+7, first pixel in the top byte.
    function automatic logic [63:0] mword(input int k, input int n);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            int r;
            r = 8 * k + j;
            w = {w[55:0], (r < n) ? m_snap[r] : 8'h00};
        end
        return w;
    endfunction

    function automatic logic [15:0] bsum(input logic [63:0] w);
        logic [15:0] s;
        logic [63:0] t;
        s = '0;
        t = w;
        for (int j = 0; j < 8; j++) begin
            s = s + {8'h00, t[7:0]};
            t = t >> 8;
        end
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_k <= 0;
            e_ena <= 1'b0; e_addr <= '0; e_din <= '0; e_din2 <= '0;
            e_busy <= 1'b0; e_done <= 1'b0; e_csum <= '0;
        end else begin
            e_ena  <= 1'b0;
            e_done <= 1'b0;
            case (m_phase)
                0: if (start) begin
                    foreach (cur_raster[i]) m_snap[i] <= cur_raster[i];
                    m_k <= 0; e_busy <= 1'b1; e_csum <= '0; m_phase <= 1;
                end
                1: if (m_k == DEPTH) begin
                    m_phase <= 2;
                end else if (gnt) begin
                    e_ena  <= 1'b1;
                    e_addr <= AW'(m_k);
                    e_din  <= mword(m_k, NUM);
                    e_din2 <= mword(m_k, NUM2);
                    e_csum <= e_csum + bsum(mword(m_k, NUM));
                    m_k    <= m_k + 1;
                end
                default: begin
                    e_done <= 1'b1; e_busy <= 1'b0; m_phase <= 0;
                end
            endcase
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (o_ena !== e_ena || o_wea !== e_ena || o_addr !== e_addr ||
                o_din !== e_din || o_busy !== e_busy || o_done !== e_done ||
                o2_ena !== e_ena || o2_wea !== e_ena || o2_addr !== e_addr ||
                o2_din !== e_din2 || o2_busy !== e_busy || o2_done !== e_done) begin
                errors++;
                $display("FAIL cycle t=%0t ena %b/%b wea %b addr %0d/%0d din %h/%h din2 %h/%h busy %b/%b done %b/%b (actual/required)",
                         $time, o_ena, e_ena, o_wea, o_addr, e_addr, o_din, e_din,
                         o2_din, e_din2, o_busy, e_busy, o_done, e_done);
            end
`ifdef IMG_WR_CHECKSUM_EN
            checks++;
            if (o_csum !== e_csum) begin
                errors++;
                $display("FAIL checksum t=%0t actual %h required %h", $time, o_csum, e_csum);
            end
`endif
        end
    end

    // ---------------- write monitor ----------------
    logic [AW-1:0] wq_addr [$];
    logic [DW-1:0] wq_din  [$];
    int            done_cnt = 0;
    logic [DW-1:0] d2_w97   = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_ena) begin
                wq_addr.push_back(o_addr);
                wq_din.push_back(o_din);
            end
            if (o2_ena && o2_addr == AW'(97)) d2_w97 = o2_din;
            if (o_done) done_cnt++;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic set_image(input int mode);
        for (int i = 0; i < NUM; i++) begin
            byte unsigned v;
            case (mode)
                0:       v = 8'(i % 256);
                1:       v = 8'hAA;
                2:       v = 8'hFF;
                default: v = 8'($urandom_range(0, 255));
            endcase
            cur_raster[i]  = v;
            img[NUM-1-i]   = v;
            if (i < NUM2) img2[NUM2-1-i] = v;
        end
    endtask

    function automatic logic [63:0] ramp_word(input int k);
        logic [63:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w = {w[55:0], 8'((8 * k + j) % 256)};
        return w;
    endfunction

    task automatic clear_mon();
        wq_addr.delete();
        wq_din.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input bit now);
        if (!now) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // gmode: 0 grant held high, 1 toggling starting high, 2 random
    task automatic wait_done(input int gmode, input int maxc, input int restart_at,
                             output int cyc);
        cyc = 0;
        while (o_done !== 1'b1 && cyc < maxc) begin
            case (gmode)
                0:       gnt = 1'b1;
                1:       gnt = (cyc % 2 == 0);
                default: gnt = 1'($urandom_range(0, 1));
            endcase
            start = (cyc == restart_at);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (o_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual %0d cycles required done", cyc);
        end
    endtask

    task automatic chk_ramp_writes(input string nm);
        chk({nm, "_nwrites"}, 64'(wq_addr.size()), 64'(DEPTH));
        for (int k = 0; k < wq_addr.size() && k < DEPTH; k++) begin
            chk({nm, "_addr"}, 64'(wq_addr[k]), 64'(k));
            chk({nm, "_din"}, wq_din[k], ramp_word(k));
        end
    endtask

    task automatic chk_reset_zero(input string nm);
        chk({nm, "_ena"},  64'(o_ena),  64'd0);
        chk({nm, "_wea"},  64'(o_wea),  64'd0);
        chk({nm, "_addr"}, 64'(o_addr), 64'd0);
        chk({nm, "_din"},  o_din,       64'd0);
        chk({nm, "_busy"}, 64'(o_busy), 64'd0);
        chk({nm, "_done"}, 64'(o_done), 64'd0);
`ifdef IMG_WR_CHECKSUM_EN
        chk({nm, "_csum"}, 64'(o_csum), 64'd0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        set_image(0);
        #2 rst_n = 1'b0;
        #1 chk_reset_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Ramp image, grant held high.
        clear_mon();
        gnt = 1'b1;
        do_start(1'b0);
        wait_done(0, 400, -1, cyc);
        chk("ramp_done_cycle", 64'(cyc), 64'd100);
        repeat (2) @(negedge clk);
        chk_ramp_writes("ramp");
        if (wq_din.size() == DEPTH) begin
            chk("ramp_w0_literal",  wq_din[0],  64'h0001020304050607);
            chk("ramp_w97_literal", wq_din[97], 64'h08090A0B0C0D0E0F);
        end
        chk("ramp_done_pulses", 64'(done_cnt), 64'd1);
        chk("pad780_w97", d2_w97, 64'h08090A0B00000000);

        // Toggling grant.
        clear_mon();
        do_start(1'b0);
        wait_done(1, 800, -1, cyc);
        repeat (2) @(negedge clk);
        chk_ramp_writes("toggle");
        chk("toggle_done_pulses", 64'(done_cnt), 64'd1);

        // Input changed after start, plus a second start mid-write.
        clear_mon();
        set_image(0);
        do_start(1'b0);
        set_image(1);
        wait_done(0, 400, 50, cyc);
        repeat (4) @(negedge clk);
        chk_ramp_writes("snapshot");
        chk("snapshot_done_pulses", 64'(done_cnt), 64'd1);

        // Asynchronous reset in the middle of a write sequence.
        set_image(0);
        clear_mon();
        gnt = 1'b1;
        do_start(1'b0);
        for (int c = 0; c < 300 && wq_addr.size() < 41; c++) @(negedge clk);
        chk("midrst_reached_addr40", 64'(wq_addr.size()), 64'd41);
        #2 rst_n = 1'b0;
        #1 chk_reset_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (3) @(negedge clk);
        chk("midrst_no_stale_done", 64'(done_cnt), 64'd0);
        do_start(1'b0);
        wait_done(0, 400, -1, cyc);
        repeat (2) @(negedge clk);
        chk_ramp_writes("after_rst");
        chk("after_rst_done_pulses", 64'(done_cnt), 64'd1);

        // All 0xFF image.
        clear_mon();
        set_image(2);
        do_start(1'b0);
        wait_done(0, 400, -1, cyc);
`ifdef IMG_WR_CHECKSUM_EN
        chk("ff_checksum", 64'(o_csum), 64'h0CF0);
`endif
        repeat (2) @(negedge clk);
        if (wq_din.size() > 0) chk("ff_w0", wq_din[0], 64'hFFFFFFFFFFFFFFFF);
        chk("ff_nwrites", 64'(wq_addr.size()), 64'(DEPTH));

        // Random images, random grant; later runs restart on the done cycle.
        for (int r = 0; r < 4; r++) begin
            clear_mon();
            set_image(3);
            do_start(r != 0);
            wait_done(2, 3000, -1, cyc);
            chk("rand_nwrites", 64'(wq_addr.size()), 64'(DEPTH));
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
